// File: rtl/async_sram_phy_ws_pkg.sv
// Shared types and width helpers for the wait-state async SRAM PHY.
package async_sram_phy_ws_pkg;

  localparam int unsigned W_CNT = 4;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRd     = 3'd1,
    StTurn   = 3'd2,
    StWsetup = 3'd3,
    StWpulse = 3'd4,
    StWhold  = 3'd5,
    StRsync  = 3'd6
  } phy_state_e;

  function automatic int unsigned w_bytes(input int unsigned w_data);
    return w_data / 8;
  endfunction

endpackage

// File: rtl/sram_phy_ws_timer.sv
// Loadable down-counter shared by the timed PHY states; done while the count is zero.
module sram_phy_ws_timer
  import async_sram_phy_ws_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [W_CNT-1:0] load_val_i,
  output logic             done_o
);

  logic [W_CNT-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/async_sram_phy_ws.sv
// Async SRAM PHY with configurable read/write wait states, read-to-write turnaround and an
// optional DQ input flop. Every pad output comes straight from a flop.
module async_sram_phy_ws
  import async_sram_phy_ws_pkg::*;
#(
  parameter int unsigned W_ADDR     = 18,
  parameter int unsigned W_DATA     = 16,
  parameter int unsigned READ_WAIT  = 1,
  parameter int unsigned WRITE_WAIT = 1,
  parameter int unsigned TURNAROUND = 1,
  parameter int unsigned DQ_SYNC_IN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [W_ADDR-1:0]     req_addr,
  input  logic [W_DATA-1:0]     req_wdata,
  input  logic [W_DATA/8-1:0]   req_bmask,
  output logic                  rsp_valid,
  output logic [W_DATA-1:0]     rsp_rdata,
  output logic [W_ADDR-1:0]     sram_addr,
  inout  wire  [W_DATA-1:0]     sram_dq,
  output logic                  sram_ce_n,
  output logic                  sram_we_n,
  output logic                  sram_oe_n,
  output logic [W_DATA/8-1:0]   sram_byte_n
);

  localparam int unsigned W_BYTES = w_bytes(W_DATA);
  localparam logic [W_CNT-1:0] RdLoad   = W_CNT'(READ_WAIT);
  localparam logic [W_CNT-1:0] WrLoad   = W_CNT'(WRITE_WAIT);
  localparam logic [W_CNT-1:0] TurnLoad = W_CNT'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

  phy_state_e         state_q, state_d;
  logic               prev_rd_q, prev_rd_d;
  logic               ready_q, ready_d;
  logic [W_ADDR-1:0]  addr_q, addr_d;
  logic [W_DATA-1:0]  wdata_q, wdata_d;
  logic [W_BYTES-1:0] bmask_q, bmask_d;
  logic [W_DATA-1:0]  dq_in_q, dq_in_d;
  logic [W_DATA-1:0]  rdata_q, rdata_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic [W_BYTES-1:0] byte_n_q, byte_n_d;
  logic [W_DATA-1:0]  dq_oe_q, dq_oe_d;

  logic             accept;
  logic             tmr_load, tmr_done;
  logic [W_CNT-1:0] tmr_val;
  logic             wr_en;

  sram_phy_ws_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  assign accept = req_valid && ready_q;

  always_comb begin
    state_d     = state_q;
    prev_rd_d   = prev_rd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    bmask_d     = bmask_q;
    dq_in_d     = dq_in_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          bmask_d = req_bmask;
          if (!req_write) begin
            state_d   = StRd;
            prev_rd_d = 1'b1;
            tmr_load  = 1'b1;
            tmr_val   = RdLoad;
          end else begin
            prev_rd_d = 1'b0;
            if (prev_rd_q && (TURNAROUND > 0)) begin
              state_d  = StTurn;
              tmr_load = 1'b1;
              tmr_val  = TurnLoad;
            end else begin
              state_d = StWsetup;
            end
          end
        end
      end
      StRd: begin
        if (tmr_done) begin
          if (DQ_SYNC_IN != 0) begin
            dq_in_d = sram_dq;
            state_d = StRsync;
          end else begin
            rdata_d     = sram_dq;
            rsp_valid_d = 1'b1;
            state_d     = StIdle;
          end
        end
      end
      StRsync: begin
        rdata_d     = dq_in_q;
        rsp_valid_d = 1'b1;
        state_d     = StIdle;
      end
      StTurn: begin
        if (tmr_done) state_d = StWsetup;
      end
      StWsetup: begin
        state_d  = StWpulse;
        tmr_load = 1'b1;
        tmr_val  = WrLoad;
      end
      StWpulse: begin
        if (tmr_done) state_d = StWhold;
      end
      StWhold: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Pad flops are loaded from the next state so strobes line up with the state they belong to.
  always_comb begin
    ready_d  = (state_d == StIdle);
    ce_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    we_n_d   = 1'b1;
    byte_n_d = '1;
    dq_oe_d  = '0;
    wr_en    = (bmask_d != '0);
    unique case (state_d)
      StRd: begin
        ce_n_d   = 1'b0;
        oe_n_d   = 1'b0;
        byte_n_d = '0;
      end
      StWsetup, StWhold: begin
        ce_n_d   = 1'b0;
        byte_n_d = ~bmask_d;
        dq_oe_d  = {W_DATA{wr_en}};
      end
      StWpulse: begin
        ce_n_d   = 1'b0;
        we_n_d   = ~wr_en;
        byte_n_d = ~bmask_d;
        dq_oe_d  = {W_DATA{wr_en}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      prev_rd_q   <= 1'b0;
      ready_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      bmask_q     <= '0;
      dq_in_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      byte_n_q    <= '1;
      dq_oe_q     <= '0;
    end else begin
      state_q     <= state_d;
      prev_rd_q   <= prev_rd_d;
      ready_q     <= ready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      bmask_q     <= bmask_d;
      dq_in_q     <= dq_in_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      byte_n_q    <= byte_n_d;
      dq_oe_q     <= dq_oe_d;
    end
  end

  for (genvar i = 0; i < W_DATA; i++) begin : g_dq
    assign sram_dq[i] = dq_oe_q[i] ? wdata_q[i] : 1'bz;
  end

  assign req_ready   = ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign sram_addr   = addr_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_byte_n = byte_n_q;

endmodule

// File: tb/tb_async_sram_phy_ws.sv
// Scoreboard bench for async_sram_phy_ws: several parameter sets, each with its own SRAM model,
// request-level reference memory and pad-level monitor.
module tb_async_sram_phy_ws;

  localparam int NCFG  = 4;
  localparam int NRAND = 250;
  localparam int unsigned CFG_RW [NCFG] = '{0, 1, 3, 0};
  localparam int unsigned CFG_WW [NCFG] = '{2, 0, 3, 1};
  localparam int unsigned CFG_TA [NCFG] = '{2, 0, 3, 1};
  localparam int unsigned CFG_SY [NCFG] = '{1, 0, 1, 0};

  typedef struct packed {
    logic [15:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int ndone  = 0;

  task automatic chk(input string tag, input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got 0x%0h, expected 0x%0h", tag, name, act, exp);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int unsigned RW = CFG_RW[g];
    localparam int unsigned WW = CFG_WW[g];
    localparam int unsigned TA = CFG_TA[g];
    localparam int unsigned SY = CFG_SY[g];
    localparam int RD_OCC = RW + 2 + SY;
    localparam int WR_OCC = WW + 4;

    logic        rst_n, req_valid, req_ready, req_write, rsp_valid;
    logic [17:0] req_addr, sram_addr;
    logic [15:0] req_wdata, rsp_rdata, mem_out;
    logic [1:0]  req_bmask, sram_byte_n, cur_mask;
    logic        ce_n, we_n, oe_n;
    wire  [15:0] sram_dq;
    logic        phy_drv;

    logic [15:0] mem [int unsigned];
    logic [15:0] ref_mem [int unsigned];
    exp_t        exp_q [$];
    string       tag;
    int          prev_acc, prev_occ, we_total, drv_total;
    bit          last_rd;

    async_sram_phy_ws #(
      .W_ADDR     (18),
      .W_DATA     (16),
      .READ_WAIT  (RW),
      .WRITE_WAIT (WW),
      .TURNAROUND (TA),
      .DQ_SYNC_IN (SY)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_bmask   (req_bmask),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .sram_addr   (sram_addr),
      .sram_dq     (sram_dq),
      .sram_ce_n   (ce_n),
      .sram_we_n   (we_n),
      .sram_oe_n   (oe_n),
      .sram_byte_n (sram_byte_n)
    );

    // Observed pad direction of the PHY's DQ drivers.
    assign phy_drv = |u_dut.dq_oe_q;

    function automatic logic [15:0] mem_rd(input logic [17:0] a);
      return mem.exists(a) ? mem[a] : 16'h0000;
    endfunction

    function automatic logic [15:0] ref_rd(input logic [17:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    endfunction

    // Async SRAM: drives DQ while selected for read, stores enabled bytes while we_n is low.
    assign sram_dq = (!ce_n && !oe_n) ? mem_out : {16{1'bz}};
    always @(negedge clk) begin
      logic [15:0] w;
      mem_out <= mem_rd(sram_addr);
      if (!ce_n && !we_n) begin
        w = mem_rd(sram_addr);
        for (int b = 0; b < 2; b++) if (!sram_byte_n[b]) w[b*8 +: 8] = sram_dq[b*8 +: 8];
        mem[sram_addr] = w;
      end
    end

    int   oe_run = 0, we_run = 0, drv_run = 0, hz_cnt = 0;
    bit   armed = 0;
    exp_t e;
    logic [1:0] nm;
    always @(negedge clk) begin
      if (!rst_n) begin
        oe_run = 0; we_run = 0; drv_run = 0; hz_cnt = 0; armed = 0;
      end else begin
        if (!oe_n || !we_n) chk(tag, "oe_n/we_n not low together", oe_n | we_n, 1);
        if (!oe_n) chk(tag, "phy drives dq during oe_n low", phy_drv, 0);
        if (!we_n) begin
          chk(tag, "dq driven during we_n low", phy_drv, 1);
          nm = ~cur_mask;
          chk(tag, "byte_n during we_n low", sram_byte_n, nm);
        end
        if (!oe_n) oe_run++;
        else if (oe_run > 0) begin
          chk(tag, "oe_n low cycles", oe_run, RW + 1);
          oe_run = 0;
        end
        if (!we_n) begin
          we_run++; we_total++;
        end else if (we_run > 0) begin
          chk(tag, "we_n low cycles", we_run, WW + 1);
          we_run = 0;
        end
        if (oe_n && phy_drv) begin
          drv_run++; drv_total++;
        end else if (drv_run > 0) begin
          chk(tag, "dq driven cycles per write", drv_run, WW + 3);
          drv_run = 0;
        end
        if (!oe_n) begin
          armed = 1; hz_cnt = 0;
        end else if (armed) begin
          if (phy_drv) begin
            chk(tag, "hi-z gap after oe_n rise >= 1+TA", hz_cnt >= int'(1 + TA), 1);
            armed = 0;
          end else begin
            hz_cnt++;
          end
        end
        if (rsp_valid) begin
          if (exp_q.size() == 0) begin
            chk(tag, "rsp_valid with no pending read", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            chk(tag, "read data", rsp_rdata, e.data);
            chk(tag, "read latency (cycle)", cyc, e.due);
          end
        end
      end
    end

    task automatic issue(input bit wr, input logic [17:0] a, input logic [15:0] d,
                         input logic [1:0] m, input bit b2b);
      int acc, tmo;
      logic [15:0] w;
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_bmask = m;
      tmo = 0;
      while (!req_ready && tmo < 200) begin
        @(negedge clk);
        tmo++;
      end
      if (!req_ready) begin
        chk(tag, "req_ready timeout", req_ready, 1);
        req_valid = 1'b0;
        return;
      end
      acc = cyc + 1;
      if (wr) cur_mask = m;
      if (b2b) chk(tag, "accept-to-accept occupancy", acc - prev_acc, prev_occ);
      if (wr) begin
        w = ref_rd(a);
        for (int b = 0; b < 2; b++) if (m[b]) w[b*8 +: 8] = d[b*8 +: 8];
        ref_mem[a] = w;
        prev_occ = WR_OCC + ((last_rd && TA > 0) ? int'(TA) : 0);
        last_rd = 0;
      end else begin
        exp_q.push_back('{data: ref_rd(a), due: acc + RD_OCC - 1});
        prev_occ = RD_OCC;
        last_rd = 1;
      end
      prev_acc = acc;
      @(negedge clk);
      req_valid = 1'b0;
    endtask

    initial begin
      int tmo, we0, drv0, gap;
      tag = $sformatf("cfg%0d", g);
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
      req_wdata = '0; req_bmask = '0; cur_mask = '0;
      last_rd = 0; prev_acc = 0; prev_occ = 0; we_total = 0; drv_total = 0;
      mem[18'h01234] = 16'hBEEF; ref_mem[18'h01234] = 16'hBEEF;
      mem[18'h3FFFF] = 16'h1111; ref_mem[18'h3FFFF] = 16'h1111;

      @(negedge clk);
      chk(tag, "reset req_ready", req_ready, 0);
      chk(tag, "reset rsp_valid", rsp_valid, 0);
      chk(tag, "reset rsp_rdata", rsp_rdata, 0);
      chk(tag, "reset ce/oe/we", {ce_n, oe_n, we_n}, 3'b111);
      chk(tag, "reset byte_n", sram_byte_n, 2'b11);
      chk(tag, "reset sram_addr", sram_addr, 0);
      chk(tag, "reset dq hi-z", phy_drv, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk(tag, "req_ready on first edge after release", req_ready, 1);

      issue(0, 18'h01234, 16'h0, 2'b00, 0);
      repeat (8) @(negedge clk);
      issue(1, 18'h3FFFF, 16'hA55A, 2'b10, 0);
      repeat (12) @(negedge clk);
      chk(tag, "masked write updates high byte only", mem_rd(18'h3FFFF), 16'hA511);

      // Read, write, zero-mask write, read: all back-to-back.
      we0 = we_total; drv0 = drv_total;
      issue(0, 18'h3FFFF, 16'h0, 2'b00, 0);
      issue(1, 18'h00005, 16'h1234, 2'b11, 1);
      issue(1, 18'h00005, 16'hFFFF, 2'b00, 1);
      issue(0, 18'h00005, 16'h0, 2'b00, 1);
      repeat (15) @(negedge clk);
      chk(tag, "we_n low cycles over sequence", we_total - we0, WW + 1);
      chk(tag, "dq driven cycles over sequence", drv_total - drv0, WW + 3);

      // Reset during the write pulse.
      issue(1, 18'h00007, 16'h5A5A, 2'b11, 0);
      tmo = 0;
      while (we_n && tmo < 50) begin
        @(negedge clk);
        tmo++;
      end
      chk(tag, "we_n low reached before reset", we_n, 0);
      #1 rst_n = 1'b0;
      #1;
      chk(tag, "strobes high at once on reset", {ce_n, oe_n, we_n}, 3'b111);
      chk(tag, "dq hi-z at once on reset", phy_drv, 0);
      chk(tag, "byte_n high at once on reset", sram_byte_n, 2'b11);
      repeat (3) begin
        @(negedge clk);
        chk(tag, "no rsp_valid during reset", rsp_valid, 0);
      end
      last_rd = 0;
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk(tag, "req_ready on first edge after mid-op reset", req_ready, 1);
      issue(0, 18'h00007, 16'h0, 2'b00, 0);

      for (int i = 0; i < NRAND; i++) begin
        gap = $urandom_range(0, 3);
        repeat (gap) @(negedge clk);
        issue(1'($urandom_range(0, 1)), 18'($urandom_range(0, 31)), 16'($urandom),
              2'($urandom_range(0, 3)), gap == 0);
      end
      repeat (20) @(negedge clk);
      chk(tag, "all reads answered", exp_q.size(), 0);
      ndone++;
    end
  end

  initial begin
    int t = 0;
    while (ndone < NCFG && t < 90000) begin
      @(posedge clk);
      t++;
    end
    if (ndone < NCFG) begin
      checks++;
      errors++;
      $display("FAIL run timeout: got %0d finished configs, expected %0d", ndone, NCFG);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
